ntt_r16_stage_scheduler: RTL and testbench

Sequences a radix-16 NTT pass over the memory-index pipeline. Each cycle it issues one butterfly-group read (stage, group) into the fixed-latency index/enable delay line. It counts groups in flight using the delay line's returning enable, and holds a barrier between stages until every write-back of the current stage has retired. Sits between the top-level NTT control and the address generator / delay buffer.

---
 rtl/ntt_r16_stage_scheduler.sv | 146 ++++++++++++++
 tb/tb_ntt_r16_stage_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_r16_stage_scheduler.sv
// rtl/ntt_r16_stage_scheduler.sv - radix-16 NTT stage/group issue scheduler with stage barrier
// Optional NTT_SCHED_PERF_EN adds stall_cycles/drain_cycles performance counters.
module ntt_r16_stage_scheduler #(
  parameter int STAGE_NUM        = 3,
  parameter int GROUPS_PER_STAGE = 256,
  parameter int PIPE_LAT         = 12,
  parameter int MAX_INFLIGHT     = 16,
  localparam int SW = $clog2(STAGE_NUM),
  localparam int GW = $clog2(GROUPS_PER_STAGE),
  localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          wb_valid,
  output logic          busy,
  output logic          issue_valid,
  output logic [SW-1:0] issue_stage,
  output logic [GW-1:0] issue_group,
  output logic          stage_last,
  output logic          done,
  output logic [IW-1:0] inflight,
  output logic          err_underflow
`ifdef NTT_SCHED_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   drain_cycles
`endif
);

  // The delay line retires every group exactly PIPE_LAT cycles after issue,
  // so a credit limit beyond that depth can never be reached.
  localparam int CREDIT = (MAX_INFLIGHT < PIPE_LAT) ? MAX_INFLIGHT : PIPE_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] stage_q, stage_nx;
  logic [GW-1:0] group_q, group_nx;
  logic [IW-1:0] inflight_q;
  logic          err_q;
  logic          last_group, last_stage, issue_ok, drained;

  assign last_group = (group_q == GW'(GROUPS_PER_STAGE - 1));
  assign last_stage = (stage_q == SW'(STAGE_NUM - 1));
  // A same-cycle retire frees a credit, keeping the issue pattern back-to-back.
  assign issue_ok   = (state == ISSUE) && !stall &&
                      ((inflight_q < IW'(CREDIT)) || wb_valid);
  assign drained    = (inflight_q == '0) || ((inflight_q == IW'(1)) && wb_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      stage_q <= '0;
      group_q <= '0;
    end else begin
      state   <= state_nx;
      stage_q <= stage_nx;
      group_q <= group_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stage_nx = stage_q;
    group_nx = group_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          stage_nx = '0;
          group_nx = '0;
        end
      end
      ISSUE: begin
        if (issue_ok) begin
          if (last_group) begin
            group_nx = '0;
            state_nx = DRAIN;
          end else begin
            group_nx = group_q + GW'(1);
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          if (!last_stage) begin
            stage_nx = stage_q + SW'(1);
            state_nx = ISSUE;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case ({issue_ok, wb_valid})
        2'b10: inflight_q <= inflight_q + IW'(1);
        2'b01: begin
          if (inflight_q == '0) err_q <= 1'b1;
          else                  inflight_q <= inflight_q - IW'(1);
        end
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign issue_valid   = issue_ok;
  assign issue_stage   = stage_q;
  assign issue_group   = group_q;
  assign stage_last    = issue_ok && last_group;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

`ifdef NTT_SCHED_PERF_EN
  logic [31:0] stall_q, drain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      drain_q <= '0;
    end else if (state == IDLE && start) begin
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      if (state == ISSUE && !issue_ok && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (state == DRAIN && drain_q != '1)              drain_q <= drain_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign drain_cycles = drain_q;
`endif

endmodule

// File: tb/tb_ntt_r16_stage_scheduler.sv
// tb/tb_ntt_r16_stage_scheduler.sv - directed self-checking bench for ntt_r16_stage_scheduler
module tb_ntt_r16_stage_scheduler;

  logic       clk, rst, start, stall, wb_force, line_en;
  logic       wb_valid, busy, issue_valid, stage_last, done, err_underflow;
  logic [1:0] issue_stage;
  logic [7:0] issue_group;
  logic [4:0] inflight;
  logic [11:0] sr;

  logic       start2, stall2, wb2, busy2, issue_valid2, stage_last2, done2, err2;
  logic       issue_stage2;
  logic [3:0] issue_group2;
  logic [2:0] inflight2;
  logic [11:0] sr2;

  int vectors = 0;
  int fails   = 0;

`ifdef NTT_SCHED_PERF_EN
  logic [31:0] stall_cycles, drain_cycles, stall_cycles2, drain_cycles2;
`endif

  ntt_r16_stage_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .wb_valid(wb_valid),
    .busy(busy), .issue_valid(issue_valid), .issue_stage(issue_stage),
    .issue_group(issue_group), .stage_last(stage_last), .done(done),
    .inflight(inflight), .err_underflow(err_underflow)
`ifdef NTT_SCHED_PERF_EN
    , .stall_cycles(stall_cycles), .drain_cycles(drain_cycles)
`endif
  );

  ntt_r16_stage_scheduler #(.STAGE_NUM(2), .GROUPS_PER_STAGE(16), .PIPE_LAT(12), .MAX_INFLIGHT(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stall(stall2), .wb_valid(wb2),
    .busy(busy2), .issue_valid(issue_valid2), .issue_stage(issue_stage2),
    .issue_group(issue_group2), .stage_last(stage_last2), .done(done2),
    .inflight(inflight2), .err_underflow(err2)
`ifdef NTT_SCHED_PERF_EN
    , .stall_cycles(stall_cycles2), .drain_cycles(drain_cycles2)
`endif
  );

  // 12-cycle delay-line models; reset by the same rst as the scheduler.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      sr2 <= '0;
    end else begin
      sr  <= {sr[10:0], issue_valid & line_en};
      sr2 <= {sr2[10:0], issue_valid2};
    end
  end
  assign wb_valid = sr[11] | wb_force;
  assign wb2      = sr2[11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transform; cycle c is the c-th clock period after the edge that accepts start.
  task automatic run(input string tag, input int st_lo, input int st_hi, input int mid_start, input int exp_done);
    int iss, lasts, seqerr, drains, maxinf, done_at, exp_g, exp_s;
    iss = 0; lasts = 0; seqerr = 0; drains = 0; maxinf = 0; done_at = 0; exp_g = 0; exp_s = 0;
    line_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 2000 && done_at == 0; c++) begin
      stall = (c >= st_lo && c <= st_hi);
      start = (c == mid_start);
      #2;
      if (issue_valid) begin
        if (int'(issue_group) != exp_g || int'(issue_stage) != exp_s ||
            stage_last != (exp_g == 255) || stall) seqerr++;
        iss++;
        if (exp_g == 255) begin lasts++; exp_g = 0; exp_s++; end
        else exp_g++;
      end else begin
        if (stage_last) seqerr++;
        if (stall) begin
          if (int'(issue_group) != 5) seqerr++;
        end else if (busy && !done) drains++;
      end
      if (int'(inflight) > maxinf) maxinf = int'(inflight);
      if (done) done_at = c;
      @(posedge clk); #1;
    end
    stall = 1'b0; start = 1'b0;
    check({tag, "_issues"}, iss, 768);
    check({tag, "_stage_last"}, lasts, 3);
    check({tag, "_sequence"}, seqerr, 0);
    check({tag, "_drain_cycles"}, drains, 36);
    check({tag, "_max_inflight"}, maxinf, 12);
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_busy_after"}, {31'd0, busy}, 0);
    check({tag, "_inflight_after"}, {27'd0, inflight}, 0);
  endtask

  initial begin
    int found, perr, max2, done2_seen;
    rst = 1'b1; start = 1'b0; stall = 1'b0; wb_force = 1'b0; line_en = 1'b1;
    start2 = 1'b0; stall2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_issue_valid", {31'd0, issue_valid}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_inflight", {27'd0, inflight}, 0);
    check("rst_err", {31'd0, err_underflow}, 0);
    check("rst_group", {24'd0, issue_group}, 0);
`ifdef NTT_SCHED_PERF_EN
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_drain_cycles", drain_cycles, 0);
`endif
    rst = 1'b0;

    // Retire strobe while idle
    @(posedge clk); #1; wb_force = 1'b1;
    @(posedge clk); #1; wb_force = 1'b0;
    @(posedge clk); #1;
    check("idle_wb_err", {31'd0, err_underflow}, 1);
    check("idle_wb_inflight", {27'd0, inflight}, 0);

    run("nostall", 0, -1, 400, 805);
    check("err_sticky", {31'd0, err_underflow}, 1);
`ifdef NTT_SCHED_PERF_EN
    check("nostall_perf_stall", stall_cycles, 0);
    check("nostall_perf_drain", drain_cycles, 36);
`endif

    // Stage-relative cycles 5-9 stalled
    run("stall", 6, 10, 0, 810);
`ifdef NTT_SCHED_PERF_EN
    check("stall_perf_stall", stall_cycles, 5);
    check("stall_perf_drain", drain_cycles, 36);
`endif

    // Asynchronous reset in the middle of the stage-1 drain
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      #2;
      if (issue_valid && stage_last && issue_stage == 2'd1) found = 1;
      @(posedge clk); #1;
    end
    check("drain_reached", found, 1);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_err", {31'd0, err_underflow}, 1);
    check("pre_rst_stage", {30'd0, issue_stage}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_inflight", {27'd0, inflight}, 0);
    check("mid_rst_stage", {30'd0, issue_stage}, 0);
    check("mid_rst_err", {31'd0, err_underflow}, 0);
    @(negedge clk); rst = 1'b0;
    run("rerun", 0, -1, 0, 805);
    check("rerun_err", {31'd0, err_underflow}, 0);

    // Manual retire: issue 3 groups, then one issue with a same-cycle retire
    line_en = 1'b0; stall = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; stall = 1'b1;
    #1;
    check("manual_inflight3", {27'd0, inflight}, 3);
    check("manual_group3", {24'd0, issue_group}, 3);
    stall = 1'b0; wb_force = 1'b1;
    #1;
    check("manual_issue_and_retire", {31'd0, issue_valid}, 1);
    @(posedge clk); #1; wb_force = 1'b0; stall = 1'b1;
    #1;
    check("manual_inflight_hold", {27'd0, inflight}, 3);
    check("manual_group4", {24'd0, issue_group}, 4);
    check("manual_no_underflow", {31'd0, err_underflow}, 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; stall = 1'b0; line_en = 1'b1;

    // Credit-limited instance: 4 issues then an 8-cycle gap
    perr = 0; max2 = 0; done2_seen = 0;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int c = 1; c <= 600 && done2_seen == 0; c++) begin
      #2;
      if (c <= 26 && issue_valid2 !== (((c - 1) % 12) < 4)) perr++;
      if (int'(inflight2) > max2) max2 = int'(inflight2);
      if (done2) done2_seen = 1;
      @(posedge clk); #1;
    end
    check("credit_pattern", perr, 0);
    check("credit_max_inflight", max2, 4);
    check("credit_done", done2_seen, 1);
    check("credit_final_stage", {31'd0, issue_stage2}, 1);
    check("credit_final_group", {28'd0, issue_group2}, 0);
    check("credit_busy_after", {30'd0, busy2, stage_last2}, 0);
    check("credit_err", {31'd0, err2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
